lab3_g29_gate_test_sequencer: RTL and testbench

Sequencer that exercises one 2-input combinational gate under test (NOR, AND, etc.) through all four input combinations. It compares each sampled output against a 4-bit expected truth table and reports pass/fail with a per-vector error mask. It sits between the lab's gate modules and the board-level switches/LEDs: start button in, result LEDs out. It replaces manual vector stepping with a self-checking run.

---
 rtl/lab3_g29_pkg.sv | 22 ++
 rtl/lab3_g29_gate_test_sequencer_settle_timer.sv | 34 +++
 rtl/lab3_g29_gate_test_sequencer.sv | 126 ++++++++++++
 tb/tb_lab3_g29_gate_test_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_g29_pkg.sv
// Shared types and constants for the gate test sequencer.
package lab3_g29_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int unsigned NUM_VECTORS = 4;

   // Truth tables: bit i is the required output for vector i = {a, b}.
   localparam logic [3:0] TT_NOR = 4'b0001;
   localparam logic [3:0] TT_AND = 4'b1000;
   localparam logic [3:0] TT_OR  = 4'b1110;
   localparam logic [3:0] TT_XOR = 4'b0110;

   // Index of the final vector in a run.
   localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

endpackage

// File: rtl/lab3_g29_gate_test_sequencer_settle_timer.sv
// Load/count-down timer that measures how long a vector is held before sampling.
module lab3_g29_settle_timer #(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic zero
);

   localparam int unsigned W = (SETTLE + 1 > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [W-1:0] LOAD_VAL = W'(SETTLE - 1);
   localparam logic [W-1:0] ONE      = W'(1);

   logic [W-1:0] cnt;

   // Loading SETTLE-1 makes zero rise on the SETTLE-th enabled cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   // Zero flag drives the DRIVE -> SAMPLE decision.
   always_comb begin
      zero = (cnt == '0);
   end

endmodule

// File: rtl/lab3_g29_gate_test_sequencer.sv
// Steps a 2-input gate through all four input vectors and checks each
// sampled output against a latched truth table.
module lab3_g29_gate_test_sequencer
   import lab3_g29_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] expected,
   input  logic       y_i,
   output logic       a_o,
   output logic       b_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_mask,
   output logic [2:0] err_count
);

   state_t     state;
   state_t     state_next;
   logic [1:0] idx;
   logic [1:0] idx_inc;
   logic [3:0] expected_q;
   logic       pass_q;
   logic       timer_load;
   logic       timer_en;
   logic       timer_zero;
   logic       accept;
   logic       mismatch;

   // Strobes shared by the timer and the datapath.
   always_comb begin
      accept     = (state == IDLE) && start;
      mismatch   = (y_i != expected_q[idx]);
      idx_inc    = idx + 2'd1;
      timer_load = accept || ((state == SAMPLE) && (idx != LAST_IDX));
      timer_en   = (state == DRIVE);
   end

   lab3_g29_settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .en    (timer_en),
      .zero  (timer_zero)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = DRIVE;
         DRIVE:   if (timer_zero) state_next = SAMPLE;
         SAMPLE:  state_next = (idx == LAST_IDX) ? DONE : DRIVE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Vector index, gate inputs, latched table and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= 2'd0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         expected_q <= 4'd0;
         err_mask   <= 4'd0;
         err_count  <= 3'd0;
         pass_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               a_o <= 1'b0;
               b_o <= 1'b0;
               if (start) begin
                  expected_q <= expected;
                  err_mask   <= 4'd0;
                  err_count  <= 3'd0;
                  pass_q     <= 1'b0;
                  idx        <= 2'd0;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_mask[idx] <= 1'b1;
                  err_count     <= err_count + 3'd1;
               end
               // Inputs only move here, so the gate never sees a mid-settle change.
               if (idx != LAST_IDX) begin
                  idx <= idx_inc;
                  a_o <= idx_inc[1];
                  b_o <= idx_inc[0];
               end
            end
            DONE: begin
               pass_q <= (err_mask == 4'd0);
               a_o    <= 1'b0;
               b_o    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Status outputs; pass is live in DONE so it is valid with the done pulse.
   always_comb begin
      busy = (state == DRIVE) || (state == SAMPLE);
      done = (state == DONE);
      pass = (state == DONE) ? (err_mask == 4'd0) : pass_q;
   end

endmodule

// File: tb/tb_lab3_g29_gate_test_sequencer.sv
// Self-checking bench: two sequencers (SETTLE=2 and SETTLE=1) each driving a
// modelled gate, checked every cycle against a timeline model of a run.
module tb_lab3_g29_gate_test_sequencer;
   import lab3_g29_pkg::*;

   localparam int G_NOR = 0;
   localparam int G_AND = 1;
   localparam int G_OR  = 2;
   localparam int G_XOR = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_v [2];
   logic [3:0] exp_v   [2];
   logic       y_v     [2];
   logic       a_v     [2];
   logic       b_v     [2];
   logic       busy_v  [2];
   logic       done_v  [2];
   logic       pass_v  [2];
   logic [3:0] mask_v  [2];
   logic [2:0] cnt_v   [2];
   int         gsel    [2];

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   function automatic logic gate_out(input int sel, input logic a, input logic b);
      case (sel)
         G_NOR:   return ~(a | b);
         G_AND:   return a & b;
         G_OR:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic int settle_of(input int g);
      return (g == 0) ? 2 : 1;
   endfunction

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         lab3_g29_gate_test_sequencer #(
            .SETTLE ((g == 0) ? 2 : 1)
         ) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start_v[g]),
            .expected  (exp_v[g]),
            .y_i       (y_v[g]),
            .a_o       (a_v[g]),
            .b_o       (b_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .pass      (pass_v[g]),
            .err_mask  (mask_v[g]),
            .err_count (cnt_v[g])
         );
         assign y_v[g] = gate_out(gsel[g], a_v[g], b_v[g]);
      end
   endgenerate

   task automatic check(input string name, input int g, input logic [7:0] act,
                        input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %0h, required %0h", name, g, $time, act, req);
      end
   endtask

   // Run model: r counts edges since the accepting edge; a run is
   // 4*(S+1) cycles of vectors followed by one done cycle.
   bit         run_m  [2];
   int         r_m    [2];
   logic [3:0] full_m [2];
   bit         have_m [2];

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         int s;
         logic [1:0] v;
         s = settle_of(g);
         if (reset) begin
            run_m[g]  = 1'b0;
            have_m[g] = 1'b0;
         end else if (!run_m[g]) begin
            if (start_v[g]) begin
               run_m[g]  = 1'b1;
               r_m[g]    = 0;
               have_m[g] = 1'b0;
               for (int i = 0; i < 4; i++) begin
                  v = 2'(i);
                  full_m[g][i] = gate_out(gsel[g], v[1], v[0]) ^ exp_v[g][i];
               end
            end
         end else if (r_m[g] == 4 * (s + 1)) begin
            run_m[g]  = 1'b0;
            have_m[g] = 1'b1;
         end else begin
            r_m[g]++;
         end
      end
   end

   // Compare every DUT output against the model each cycle.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         for (int g = 0; g < 2; g++) begin
            int s, idx;
            logic e_busy, e_done, e_pass, e_a, e_b, chk_ab;
            logic [3:0] e_mask, low;
            s = settle_of(g);
            e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
            e_a = 1'b0; e_b = 1'b0; chk_ab = 1'b1;
            if (run_m[g] && (r_m[g] < 4 * (s + 1))) begin
               idx    = r_m[g] / (s + 1);
               e_busy = 1'b1;
               e_a    = (idx >= 2);
               e_b    = (idx % 2 == 1);
               low    = 4'((1 << idx) - 1);
               e_mask = full_m[g] & low;
            end else if (run_m[g]) begin
               e_done = 1'b1;
               e_mask = full_m[g];
               e_pass = (full_m[g] == 4'd0);
               chk_ab = 1'b0;
            end else begin
               e_mask = have_m[g] ? full_m[g] : 4'd0;
               e_pass = have_m[g] && (full_m[g] == 4'd0);
            end
            check("busy", g, 8'(busy_v[g]), 8'(e_busy));
            check("done", g, 8'(done_v[g]), 8'(e_done));
            check("pass", g, 8'(pass_v[g]), 8'(e_pass));
            check("err_mask", g, 8'(mask_v[g]), 8'(e_mask));
            check("err_count", g, 8'(cnt_v[g]), 8'($countones(e_mask)));
            if (chk_ab) begin
               check("a_o", g, 8'(a_v[g]), 8'(e_a));
               check("b_o", g, 8'(b_v[g]), 8'(e_b));
            end
         end
      end
   end

   // Start a run on instance g and wait (bounded) for its done pulse.
   task automatic run_wait(input int g, input int gate, input logic [3:0] tt,
                           output int edges, output logic [3:0] m,
                           output logic p, output logic [2:0] c);
      @(negedge clk);
      gsel[g]    = gate;
      exp_v[g]   = tt;
      start_v[g] = 1'b1;
      @(posedge clk);
      #1;
      start_v[g] = 1'b0;
      edges = 0;
      m = 4'hx; p = 1'bx; c = 3'hx;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (done_v[g]) begin
            edges = k;
            m = mask_v[g];
            p = pass_v[g];
            c = cnt_v[g];
            break;
         end
      end
   endtask

   initial begin
      int         edges, ndone, last;
      logic [3:0] m;
      logic       p;
      logic [2:0] c;

      reset = 1'b1;
      for (int g = 0; g < 2; g++) begin
         start_v[g] = 1'b0;
         exp_v[g]   = 4'd0;
         gsel[g]    = G_NOR;
      end
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Reset state after idling.
      repeat (5) @(negedge clk);
      check("rst_busy", 0, 8'(busy_v[0]), 8'd0);
      check("rst_ab", 0, 8'({a_v[0], b_v[0]}), 8'd0);
      check("rst_mask", 0, 8'(mask_v[0]), 8'd0);
      check("rst_pass", 0, 8'(pass_v[0]), 8'd0);

      // NOR gate, NOR table: clean pass, done 12 edges after the accept edge.
      run_wait(0, G_NOR, TT_NOR, edges, m, p, c);
      check("nor_latency", 0, 8'(edges), 8'd12);
      check("nor_pass", 0, 8'(p), 8'd1);
      check("nor_mask", 0, 8'(m), 8'b0000);
      check("nor_count", 0, 8'(c), 8'd0);
      repeat (3) @(negedge clk);

      // AND gate against NOR table: vectors 0 and 3 disagree.
      run_wait(0, G_AND, TT_NOR, edges, m, p, c);
      check("and_latency", 0, 8'(edges), 8'd12);
      check("and_pass", 0, 8'(p), 8'd0);
      check("and_mask", 0, 8'(m), 8'b1001);
      check("and_count", 0, 8'(c), 8'd2);
      repeat (3) @(negedge clk);

      // Noise on expected/start mid-run must not disturb the latched run.
      @(negedge clk);
      gsel[0] = G_NOR; exp_v[0] = TT_NOR; start_v[0] = 1'b1;
      ndone = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k < 10) begin
            exp_v[0]   = ~exp_v[0];
            start_v[0] = k[0];
         end else begin
            start_v[0] = 1'b0;
         end
         if (done_v[0]) ndone++;
      end
      check("noise_ndone", 0, 8'(ndone), 8'd1);
      check("noise_pass", 0, 8'(pass_v[0]), 8'd1);
      check("noise_mask", 0, 8'(mask_v[0]), 8'b0000);

      // Reset during vector 2 of an AND-vs-NOR run.
      @(negedge clk);
      gsel[0] = G_AND; exp_v[0] = TT_NOR; start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("pre_rst_busy", 0, 8'(busy_v[0]), 8'd1);
      check("pre_rst_mask", 0, 8'(mask_v[0]), 8'b0001);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", 0, 8'(busy_v[0]), 8'd0);
      check("abort_ab", 0, 8'({a_v[0], b_v[0]}), 8'd0);
      check("abort_mask", 0, 8'(mask_v[0]), 8'd0);
      check("abort_count", 0, 8'(cnt_v[0]), 8'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done_v[0]) ndone++;
      end
      check("abort_no_done", 0, 8'(ndone), 8'd0);
      run_wait(0, G_NOR, TT_NOR, edges, m, p, c);
      check("fresh_latency", 0, 8'(edges), 8'd12);
      check("fresh_pass", 0, 8'(p), 8'd1);

      // SETTLE=1, start held high: back-to-back runs, results cleared each start.
      @(negedge clk);
      gsel[1] = G_XOR; exp_v[1] = TT_NOR; start_v[1] = 1'b1;
      ndone = 0;
      last  = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (done_v[1]) begin
            if (last != 0) check("b2b_period", 1, 8'(k - last), 8'd10);
            check("b2b_mask", 1, 8'(mask_v[1]), 8'b0111);
            check("b2b_count", 1, 8'(cnt_v[1]), 8'd3);
            last = k;
            ndone++;
         end
      end
      start_v[1] = 1'b0;
      check("b2b_ndone", 1, 8'(ndone), 8'd3);
      repeat (15) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1, "watchdog");
   end

endmodule
